// File: rtl/axis_upsizer.sv
// axis_upsizer: packs (cfg_data+1) narrow AXI4-Stream beats into one wide beat,
// least-significant slice first, behind a one-deep registered output stage.
module axis_upsizer #(
    parameter int unsigned S_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned M_AXIS_TDATA_WIDTH = 128
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [15:0]                   cfg_data,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);

    localparam int unsigned SW         = S_AXIS_TDATA_WIDTH;
    localparam int unsigned MW         = M_AXIS_TDATA_WIDTH;
    localparam int unsigned RATIO      = MW / SW;
    localparam int unsigned CNTR_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNTR_WIDTH-1:0] LAST_MAX = CNTR_WIDTH'(RATIO - 1);

    logic [CNTR_WIDTH-1:0] r_cnt;
    logic [MW-1:0]         r_asm;
    logic [MW-1:0]         r_m_data;
    logic                  r_m_valid;

    logic [CNTR_WIDTH-1:0] w_cfg_last;
    logic [CNTR_WIDTH-1:0] w_last_eff;
    logic                  w_last;
    logic                  w_s_hs;
    logic [MW-1:0]         w_word;
    logic                  w_unused_cfg;

    // Only the low counter bits of cfg_data select the word length.
    assign w_cfg_last   = cfg_data[CNTR_WIDTH-1:0];
    assign w_unused_cfg = ^cfg_data[15:CNTR_WIDTH];

    // Clamp the last-slice index for non-power-of-two ratios.
    assign w_last_eff = (w_cfg_last > LAST_MAX) ? LAST_MAX : w_cfg_last;
    assign w_last     = (r_cnt >= w_last_eff);

    // Only the completing beat waits for the output stage to free up.
    assign s_axis_tready = ~w_last | ~r_m_valid | m_axis_tready;
    assign w_s_hs        = s_axis_tvalid & s_axis_tready;

    // Assembly word with the incoming beat merged in; slices above the counter read zero.
    always_comb begin
        w_word = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (CNTR_WIDTH'(i) < r_cnt) begin
                w_word[i*SW +: SW] = r_asm[i*SW +: SW];
            end else if (CNTR_WIDTH'(i) == r_cnt) begin
                w_word[i*SW +: SW] = s_axis_tdata;
            end
        end
    end

    // Slice counter and partial-word assembly register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_cnt <= '0;
            r_asm <= '0;
        end else if (w_s_hs) begin
            if (w_last) begin
                r_cnt <= '0;
                r_asm <= '0;
            end else begin
                r_cnt <= r_cnt + CNTR_WIDTH'(1);
                r_asm <= w_word;
            end
        end
    end

    // One-deep output register; a new word may load in the cycle the old one drains.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
        end else if (w_s_hs && w_last) begin
            r_m_data  <= w_word;
            r_m_valid <= 1'b1;
        end else if (m_axis_tready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_m_data;
    assign m_axis_tvalid = r_m_valid;

endmodule
